// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        OWN_IF = 2'd1,
        OWN_LS = 2'd2
    } arb_owner_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } ls_size_e;

    localparam logic [BE_W-1:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory-macro signals of the arbiter; slave = arbiter side.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 30
);
    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic [DATA_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               mem_en, mem_we, mem_addr, mem_be, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               mem_en, mem_we, mem_addr, mem_be, mem_wdata, busy
    );

endinterface

// File: rtl/mem_be_gen.sv
// Byte-enable, store-lane replication and misalignment decode for one LS access.
module mem_be_gen
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]        size_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [BE_W-1:0]   be_o,
    output logic [DATA_W-1:0] wdata_rep_o,
    output logic              misaligned_o
);

    // Size code 11 falls into the word branch.
    always_comb begin
        be_o         = BE_ALL;
        wdata_rep_o  = wdata_i;
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_B: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
            end
            SIZE_H: begin
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep_o  = {2{wdata_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            default: begin
                misaligned_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// IF/LS arbiter for a single-port synchronous memory, one transaction outstanding.
// Optional misaligned-LS trapping when MEM_ARB_MISALIGN_CHK_EN is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam int unsigned      CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(MEM_LAT - 1);
    localparam logic [0:0]       ST_IDLE = 1'(IDLE);
    localparam logic [0:0]       ST_WAIT = 1'(WAIT);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    arb_owner_e       owner_q, owner_d;
    logic             last_ls_q, last_ls_d;
    logic             err_q, err_d;

    logic              slot, resp, ls_win, gnt_if, gnt_ls, mis_chk, mis_drop;
    logic [BE_W-1:0]   ls_be;
    logic [DATA_W-1:0] ls_wrep;
    logic              ls_mis;

    logic              if_gnt_c, if_rvalid_c, ls_gnt_c, ls_rvalid_c, ls_err_c;
    logic              mem_en_c, mem_we_c, busy_c;
    logic [DATA_W-1:0] if_rdata_c, ls_rdata_c, mem_wdata_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [BE_W-1:0]   mem_be_c;

    mem_be_gen u_be_gen (
        .size_i       (bus.ls_size),
        .addr_lo_i    (bus.ls_addr[1:0]),
        .wdata_i      (bus.ls_wdata),
        .be_o         (ls_be),
        .wdata_rep_o  (ls_wrep),
        .misaligned_o (ls_mis)
    );

`ifdef MEM_ARB_MISALIGN_CHK_EN
    assign mis_chk = ls_mis;
`else
    logic unused_mis;
    assign mis_chk    = 1'b0;
    assign unused_mis = ls_mis;
`endif

    // Address bits outside the word index only feed the byte-enable decode.
    logic unused_addr;
    assign unused_addr = ^{bus.if_addr, bus.ls_addr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            owner_q   <= NONE;
            last_ls_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_ls_q <= last_ls_d;
            err_q     <= err_d;
        end
    end

    // Next state, grant and memory-side muxing; everything is masked while rst is high.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_ls_d   = last_ls_q;
        err_d       = err_q;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_be_c    = '0;
        mem_wdata_c = '0;

        slot     = (state_q == ST_IDLE) | ((state_q == ST_WAIT) & (cnt_q == '0));
        resp     = ~rst & (state_q == ST_WAIT) & (cnt_q == '0);
        ls_win   = bus.ls_req & ~(bus.if_req & last_ls_q);
        gnt_ls   = ~rst & slot & ls_win;
        gnt_if   = ~rst & slot & bus.if_req & ~ls_win;
        mis_drop = gnt_ls & mis_chk;

        if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (slot) begin
            state_d = ST_IDLE;
            owner_d = NONE;
            err_d   = 1'b0;
        end
        if (gnt_ls || gnt_if) begin
            state_d = ST_WAIT;
            cnt_d   = LAT_M1;
            owner_d = gnt_ls ? OWN_LS : OWN_IF;
            err_d   = mis_drop;
        end
        // Fairness bit moves only when both sides competed for the slot.
        if (~rst && slot && bus.if_req && bus.ls_req) begin
            last_ls_d = gnt_ls;
        end

        if (gnt_ls && !mis_drop) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.ls_we;
            mem_addr_c  = bus.ls_addr[ADDR_W+1:2];
            mem_be_c    = bus.ls_we ? ls_be : BE_ALL;
            mem_wdata_c = bus.ls_we ? ls_wrep : '0;
        end else if (gnt_if) begin
            mem_en_c    = 1'b1;
            mem_addr_c  = bus.if_addr[ADDR_W+1:2];
            mem_be_c    = BE_ALL;
        end

        if_gnt_c    = gnt_if;
        ls_gnt_c    = gnt_ls;
        if_rvalid_c = resp & (owner_q == OWN_IF);
        ls_rvalid_c = resp & (owner_q == OWN_LS);
        if_rdata_c  = if_rvalid_c ? bus.mem_rdata : '0;
        ls_rdata_c  = ls_rvalid_c ? bus.mem_rdata : '0;
        ls_err_c    = ls_rvalid_c & err_q;
        busy_c      = ~rst & ((state_q == ST_WAIT) |
                              ((bus.if_req | bus.ls_req) & ~(gnt_if | gnt_ls)));
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.if_rvalid = if_rvalid_c;
    assign bus.if_rdata  = if_rdata_c;
    assign bus.ls_gnt    = ls_gnt_c;
    assign bus.ls_rvalid = ls_rvalid_c;
    assign bus.ls_rdata  = ls_rdata_c;
    assign bus.ls_err    = ls_err_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_be    = mem_be_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.busy      = busy_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW = 30;

    typedef struct packed {
        logic        is_ls;
        logic        err;
        logic        chk_data;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        q1[$];
    exp_t        q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.ADDR_W(AW)) a1 ();
    mem_arbiter_if #(.ADDR_W(AW)) a3 ();

    // Memory data is a per-cycle stamp so a response proves which cycle it was taken in.
    assign a1.mem_rdata = {8'hD1, 24'(cyc)};
    assign a3.mem_rdata = {8'hD3, 24'(cyc)};

    mem_arbiter #(.ADDR_W(AW), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(a1.slave));
    mem_arbiter #(.ADDR_W(AW), .MEM_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(a3.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic any_out1();
        return |{a1.if_gnt, a1.if_rvalid, a1.if_rdata, a1.ls_gnt, a1.ls_rvalid, a1.ls_rdata,
                 a1.ls_err, a1.mem_en, a1.mem_we, a1.mem_addr, a1.mem_be, a1.mem_wdata, a1.busy};
    endfunction

    function automatic logic any_out3();
        return |{a3.if_gnt, a3.if_rvalid, a3.if_rdata, a3.ls_gnt, a3.ls_rvalid, a3.ls_rdata,
                 a3.ls_err, a3.mem_en, a3.mem_we, a3.mem_addr, a3.mem_be, a3.mem_wdata, a3.busy};
    endfunction

    task automatic mon(input string tg, input bit s3, input logic ig, input logic lg,
                       input logic iv, input logic lv, input logic er,
                       input logic [31:0] id, input logic [31:0] ld, input logic [7:0] tagb);
        exp_t e;
        chk({tg, "_one_gnt"}, 64'(ig & lg), 64'd0);
        if (!(iv || lv)) begin
            chk({tg, "_err_idle"}, 64'(er), 64'd0);
            return;
        end
        if ((s3 ? q3.size() : q1.size()) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_unexpected_rvalid: rvalid at cycle %0d, none required", tg, cyc);
            return;
        end
        if (s3) e = q3.pop_front();
        else    e = q1.pop_front();
        chk({tg, "_one_rvalid"}, 64'(iv & lv), 64'd0);
        chk({tg, "_owner_ls"}, 64'(lv), 64'(e.is_ls));
        chk({tg, "_resp_cycle"}, 64'(cyc), 64'(e.cyc));
        chk({tg, "_ls_err"}, 64'(er), 64'(e.err));
        if (e.chk_data) chk({tg, "_rdata"}, 64'(e.is_ls ? ld : id), 64'({tagb, e.cyc[23:0]}));
    endtask

    always @(negedge clk) if (!rst)
        mon("L1", 1'b0, a1.if_gnt, a1.ls_gnt, a1.if_rvalid, a1.ls_rvalid, a1.ls_err,
            a1.if_rdata, a1.ls_rdata, 8'hD1);
    always @(negedge clk) if (!rst)
        mon("L3", 1'b1, a3.if_gnt, a3.ls_gnt, a3.if_rvalid, a3.ls_rvalid, a3.ls_err,
            a3.if_rdata, a3.ls_rdata, 8'hD3);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic exp_ls;

    initial begin
        a1.if_req = 1'b0; a1.if_addr = '0; a1.ls_req = 1'b0; a1.ls_we = 1'b0;
        a1.ls_size = 2'b10; a1.ls_addr = '0; a1.ls_wdata = '0;
        a3.if_req = 1'b0; a3.if_addr = '0; a3.ls_req = 1'b0; a3.ls_we = 1'b0;
        a3.ls_size = 2'b10; a3.ls_addr = '0; a3.ls_wdata = '0;

        repeat (2) step();
        mid();
        chk("rst_outs_l1", 64'(any_out1()), 64'd0);
        chk("rst_outs_l3", 64'(any_out3()), 64'd0);
        step(); rst = 1'b0;

        // Single fetch, latency 1
        step(); a1.if_req = 1'b1; a1.if_addr = 32'h10;
        mid();
        chk("t1_if_gnt", 64'(a1.if_gnt), 64'd1);
        chk("t1_ls_gnt", 64'(a1.ls_gnt), 64'd0);
        chk("t1_mem_en", 64'(a1.mem_en), 64'd1);
        chk("t1_mem_we", 64'(a1.mem_we), 64'd0);
        chk("t1_mem_addr", 64'(a1.mem_addr), 64'h4);
        chk("t1_mem_be", 64'(a1.mem_be), 64'hF);
        q1.push_back('{is_ls: 1'b0, err: 1'b0, chk_data: 1'b1, cyc: cyc + 1});
        step(); a1.if_req = 1'b0;
        mid();
        chk("t1_resp_mem_en", 64'(a1.mem_en), 64'd0);
        chk("t1_resp_busy", 64'(a1.busy), 64'd1);
        step();
        mid();
        chk("t1_idle_busy", 64'(a1.busy), 64'd0);

        // Contention: grants alternate LS, IF, LS, IF
        step();
        a1.if_req = 1'b1; a1.if_addr = 32'h40;
        a1.ls_req = 1'b1; a1.ls_we = 1'b0; a1.ls_size = 2'b10; a1.ls_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            mid();
            exp_ls = (i % 2 == 0);
            chk("t2_ls_gnt", 64'(a1.ls_gnt), 64'(exp_ls));
            chk("t2_if_gnt", 64'(a1.if_gnt), 64'(!exp_ls));
            chk("t2_mem_addr", 64'(a1.mem_addr), exp_ls ? 64'h80 : 64'h10);
            q1.push_back('{is_ls: exp_ls, err: 1'b0, chk_data: 1'b1, cyc: cyc + 1});
            step();
        end

        // Byte store, back-to-back with the last contended response
        a1.if_req = 1'b0;
        a1.ls_req = 1'b1; a1.ls_we = 1'b1; a1.ls_size = 2'b00;
        a1.ls_addr = 32'h103; a1.ls_wdata = 32'h0000_00AB;
        mid();
        chk("t3b_ls_gnt", 64'(a1.ls_gnt), 64'd1);
        chk("t3b_mem_we", 64'(a1.mem_we), 64'd1);
        chk("t3b_mem_be", 64'(a1.mem_be), 64'h8);
        chk("t3b_mem_wdata", 64'(a1.mem_wdata), 64'hABAB_ABAB);
        chk("t3b_mem_addr", 64'(a1.mem_addr), 64'h40);
        q1.push_back('{is_ls: 1'b1, err: 1'b0, chk_data: 1'b0, cyc: cyc + 1});

        // Half stores, upper and lower halves
        step(); a1.ls_size = 2'b01; a1.ls_addr = 32'h102; a1.ls_wdata = 32'h0000_1234;
        mid();
        chk("t3h_mem_be_hi", 64'(a1.mem_be), 64'hC);
        chk("t3h_mem_wdata_hi", 64'(a1.mem_wdata), 64'h1234_1234);
        q1.push_back('{is_ls: 1'b1, err: 1'b0, chk_data: 1'b0, cyc: cyc + 1});
        step(); a1.ls_addr = 32'h100; a1.ls_wdata = 32'hBEEF_5678;
        mid();
        chk("t3h_mem_be_lo", 64'(a1.mem_be), 64'h3);
        chk("t3h_mem_wdata_lo", 64'(a1.mem_wdata), 64'h5678_5678);
        q1.push_back('{is_ls: 1'b1, err: 1'b0, chk_data: 1'b0, cyc: cyc + 1});

        // Misaligned word load
        step(); a1.ls_we = 1'b0; a1.ls_size = 2'b10; a1.ls_addr = 32'h102; a1.ls_wdata = '0;
        mid();
        chk("t6_ls_gnt", 64'(a1.ls_gnt), 64'd1);
`ifdef MEM_ARB_MISALIGN_CHK_EN
        chk("t6_mem_en", 64'(a1.mem_en), 64'd0);
        q1.push_back('{is_ls: 1'b1, err: 1'b1, chk_data: 1'b0, cyc: cyc + 1});
`else
        chk("t6_mem_en", 64'(a1.mem_en), 64'd1);
        chk("t6_mem_be", 64'(a1.mem_be), 64'hF);
        chk("t6_mem_addr", 64'(a1.mem_addr), 64'h40);
        q1.push_back('{is_ls: 1'b1, err: 1'b0, chk_data: 1'b1, cyc: cyc + 1});
`endif
        step(); a1.ls_req = 1'b0;
        mid();
        chk("t6_resp_no_gnt", 64'(a1.if_gnt | a1.ls_gnt | a1.mem_en), 64'd0);

        // Latency 3, back-to-back fetches
        step(); a3.if_req = 1'b1; a3.if_addr = 32'h20;
        mid();
        chk("t4_gnt0", 64'(a3.if_gnt), 64'd1);
        chk("t4_mem_addr0", 64'(a3.mem_addr), 64'h8);
        q3.push_back('{is_ls: 1'b0, err: 1'b0, chk_data: 1'b1, cyc: cyc + 3});
        for (int i = 1; i < 3; i++) begin
            step();
            mid();
            chk("t4_wait_gnt", 64'(a3.if_gnt), 64'd0);
            chk("t4_wait_mem_en", 64'(a3.mem_en), 64'd0);
            chk("t4_wait_busy", 64'(a3.busy), 64'd1);
        end
        step(); a3.if_addr = 32'h24;
        mid();
        chk("t4_gnt_b2b", 64'(a3.if_gnt), 64'd1);
        chk("t4_mem_addr1", 64'(a3.mem_addr), 64'h9);
        chk("t4_busy_b2b", 64'(a3.busy), 64'd1);
        q3.push_back('{is_ls: 1'b0, err: 1'b0, chk_data: 1'b1, cyc: cyc + 3});
        step(); a3.if_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t4_busy_tail", 64'(a3.busy), 64'd1);
            step();
        end
        mid();
        chk("t4_busy_idle", 64'(a3.busy), 64'd0);

        // Reset in the middle of a latency-3 load drops the response
        step(); a3.ls_req = 1'b1; a3.ls_we = 1'b0; a3.ls_size = 2'b10; a3.ls_addr = 32'h300;
        mid();
        chk("t5_ls_gnt", 64'(a3.ls_gnt), 64'd1);
        step(); a3.ls_req = 1'b0; rst = 1'b1;
        mid();
        chk("t5_in_rst_l3", 64'(any_out3()), 64'd0);
        chk("t5_in_rst_l1", 64'(any_out1()), 64'd0);
        step(); rst = 1'b0;
        mid();
        chk("t5_after_rst", 64'(any_out3()), 64'd0);
        step();
        mid();
        chk("t5_no_rvalid", 64'(a3.ls_rvalid), 64'd0);
        step();
        mid();
        chk("t5_still_idle", 64'(any_out3()), 64'd0);

        repeat (3) step();
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q3_drained", 64'(q3.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
